// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem word requests, buffers two {ir, pc} entries for decode.
// Latency: one cycle from an imem response to id_valid. Issue stalls when two requests are in flight or work ahead of decode reaches two.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  live_cnt_q, live_cnt_d;
    logic [1:0]  stale_cnt_q, stale_cnt_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d;
    logic        pcq_hd_q, pcq_hd_d;
    logic        buf_hd_q, buf_hd_d;
    logic [31:0] pcq_q    [2];
    logic [31:0] buf_ir_q [2];
    logic [31:0] buf_pc_q [2];

    logic [1:0]  inflight;
    logic [1:0]  ahead;
    logic        pop;
    logic        accept;
    logic        resp;
    logic        resp_live;
    logic        resp_stale;
    logic        buf_wr;
    logic        pcq_tail;
    logic        buf_tail;

    assign inflight = live_cnt_q + stale_cnt_q;
    assign ahead    = live_cnt_q + buf_cnt_q;

    assign id_valid    = (buf_cnt_q != 2'd0);
    assign id_ir       = buf_ir_q[buf_hd_q];
    assign id_pc       = buf_pc_q[buf_hd_q];
    assign id_pc_plus4 = buf_pc_q[buf_hd_q] + 32'd4;
    assign pop         = id_valid && id_ready;

    // A pop this cycle frees a buffer slot, so a full pipeline can still issue.
    assign imem_req_valid = !rst && (inflight < 2'd2) && ((ahead < 2'd2) || pop);
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding belong to requests from before a reset.
    assign resp       = imem_resp_valid && (inflight != 2'd0);
    assign resp_stale = resp && (stale_cnt_q != 2'd0);
    assign resp_live  = resp && (stale_cnt_q == 2'd0);
    assign buf_wr     = resp_live && !redirect_valid;

    assign pcq_tail = pcq_hd_q ^ inflight[0];
    assign buf_tail = buf_hd_q ^ buf_cnt_q[0];

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        live_cnt_d  = live_cnt_q;
        stale_cnt_d = stale_cnt_q;
        buf_cnt_d   = buf_cnt_q;
        buf_hd_d    = buf_hd_q ^ pop;
        pcq_hd_d    = pcq_hd_q ^ resp;
        if (redirect_valid) begin
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            live_cnt_d  = 2'd0;
            stale_cnt_d = inflight + {1'b0, accept} - {1'b0, resp};
            buf_cnt_d   = 2'd0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            live_cnt_d  = live_cnt_q + {1'b0, accept} - {1'b0, resp_live};
            stale_cnt_d = stale_cnt_q - {1'b0, resp_stale};
            buf_cnt_d   = buf_cnt_q + {1'b0, resp_live} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            live_cnt_q  <= 2'd0;
            stale_cnt_q <= 2'd0;
            buf_cnt_q   <= 2'd0;
            pcq_hd_q    <= 1'b0;
            buf_hd_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pcq_q[i]    <= RESET_PC;
                buf_ir_q[i] <= NOP_INSTR;
                buf_pc_q[i] <= RESET_PC;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            live_cnt_q  <= live_cnt_d;
            stale_cnt_q <= stale_cnt_d;
            buf_cnt_q   <= buf_cnt_d;
            pcq_hd_q    <= pcq_hd_d;
            buf_hd_q    <= buf_hd_d;
            if (accept) begin
                pcq_q[pcq_tail] <= fetch_pc_q;
            end
            if (buf_wr) begin
                buf_ir_q[buf_tail] <= imem_resp_data;
                buf_pc_q[buf_tail] <= pcq_q[pcq_hd_q];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model plus a program-order reference of the PC stream.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_ir           (id_ir),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2] ^ 30'h2A5A_C3C3, 2'b11};
    endfunction

    function automatic logic [31:0] pick_tgt();
        case ($urandom_range(3))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0200;
            2:       return 32'hFFFF_FFFE;
            default: return $urandom;
        endcase
    endfunction

    // stimulus knobs
    int          lat_lo, lat_hi, p_req_rdy, p_id_rdy, p_redir, garbage;
    logic        do_rst, force_redir, stream_chk;
    logic [31:0] force_tgt;

    // memory model: in-order responses, at most one per cycle
    logic [31:0] mq_dat[$];
    int          mq_due[$];
    int          last_due;

    // reference model state
    int          cyc, since_rst, addr_chk_at, empty_until, pops;
    logic [31:0] exp_pc, next_req, addr_chk_val, hold_pc, hold_ir;
    logic        hold_chk;

    task automatic step();
        logic        real_resp;
        logic        pop;
        logic        acc;
        logic [31:0] tgt;
        logic [31:0] diff;
        int          due;
        rst            = do_rst;
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_tgt;
        end else if (!do_rst && ($urandom_range(99) < p_redir)) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_tgt();
        end
        imem_req_ready  = ($urandom_range(99) < p_req_rdy);
        id_ready        = ($urandom_range(99) < p_id_rdy);
        real_resp       = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (garbage > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
            garbage--;
        end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq_dat[0];
            real_resp       = 1'b1;
        end

        @(negedge clk);
        if (rst) begin
            check_eq("req_valid_in_rst", imem_req_valid, 0);
            mq_dat.delete();
            mq_due.delete();
            last_due     = cyc;
            exp_pc       = RESET_PC;
            next_req     = RESET_PC;
            since_rst    = 0;
            hold_chk     = 1'b0;
            empty_until  = -1;
            addr_chk_at  = cyc + 1;
            addr_chk_val = RESET_PC;
        end else begin
            since_rst++;
            if (since_rst == 1) begin
                check_eq("rst_id_valid", id_valid, 0);
                check_eq("rst_id_ir", id_ir, NOP_INSTR);
                check_eq("rst_id_pc", id_pc, RESET_PC);
                check_eq("rst_id_pc_plus4", id_pc_plus4, RESET_PC + 32'd4);
                check_eq("rst_req_valid", imem_req_valid, 1);
            end
            if (stream_chk && since_rst >= 3 && since_rst <= 6) begin
                check_eq("stream_valid", id_valid, 1);
                check_eq("stream_pc", id_pc, 32'(4 * (since_rst - 3)));
            end
            if (cyc == addr_chk_at) check_eq("fetch_addr", imem_req_addr, addr_chk_val);
            if (cyc <= empty_until) check_eq("redir_empty", id_valid, 0);
            if (hold_chk) begin
                check_eq("hold_valid", id_valid, 1);
                check_eq("hold_pc", id_pc, hold_pc);
                check_eq("hold_ir", id_ir, hold_ir);
            end

            pop = id_valid && id_ready;
            acc = imem_req_valid && imem_req_ready;
            if (pop) begin
                check_eq("id_pc", id_pc, exp_pc);
                check_eq("id_ir", id_ir, mem_word(exp_pc));
                check_eq("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (real_resp) begin
                void'(mq_dat.pop_front());
                void'(mq_due.pop_front());
            end
            if (acc) begin
                check_eq("req_addr", imem_req_addr, next_req);
                next_req = next_req + 32'd4;
                due = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq_dat.push_back(mem_word(imem_req_addr));
                mq_due.push_back(due);
            end
            check_eq("inflight_le2", mq_due.size() <= 2, 1);

            if (redirect_valid) begin
                tgt          = {redirect_pc[31:2], 2'b00};
                exp_pc       = tgt;
                next_req     = tgt;
                addr_chk_at  = cyc + 1;
                addr_chk_val = tgt;
                empty_until  = cyc + 2;
                hold_chk     = 1'b0;
            end else begin
                diff = next_req - exp_pc;
                check_eq("ahead_le2", diff <= 32'd8, 1);
                hold_chk = id_valid && !id_ready;
                hold_pc  = id_pc;
                hold_ir  = id_ir;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic found;
        int   p0;
        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        lat_lo = 1; lat_hi = 1; p_req_rdy = 100; p_id_rdy = 100; p_redir = 0; garbage = 0;
        do_rst = 1'b1; force_redir = 1'b0; force_tgt = '0; stream_chk = 1'b1;
        cyc = 0; since_rst = 0; addr_chk_at = -1; empty_until = -1; pops = 0;
        exp_pc = RESET_PC; next_req = RESET_PC; addr_chk_val = '0; hold_pc = '0; hold_ir = '0;
        hold_chk = 1'b0; last_due = 0;
        @(posedge clk);
        #1;

        // reset then back-to-back stream from a 1-cycle memory
        step();
        do_rst = 1'b0;
        repeat (12) step();
        stream_chk = 1'b0;

        // decode stall: buffer fills and issue stops
        p_id_rdy = 0;
        repeat (6) step();
        check_eq("stall_no_issue", imem_req_valid, 0);
        p_id_rdy = 100;
        repeat (10) step();

        // 3-cycle memory, redirect with two requests outstanding
        lat_lo = 3; lat_hi = 3;
        repeat (5) step();
        force_redir = 1'b1; force_tgt = 32'h0000_0100;
        step();
        force_redir = 1'b0;
        repeat (14) step();

        // redirect coinciding with a handshake and a response, then again while draining
        lat_lo = 2; lat_hi = 2; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq_due.size() > 0 && mq_due[0] <= cyc && imem_req_valid) begin
                found = 1'b1; force_redir = 1'b1; force_tgt = 32'h0000_0300;
            end
            step();
            force_redir = 1'b0;
        end
        check_eq("redir_sync_found", found, 1);
        force_redir = 1'b1; force_tgt = 32'h0000_0200;
        step();
        force_redir = 1'b0;
        repeat (15) step();

        // unaligned target near the top of memory, fetch wraps to zero
        lat_lo = 1; lat_hi = 1;
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFE;
        step();
        force_redir = 1'b0;
        repeat (8) step();

        // reset with two requests in flight; late responses straddle it
        lat_lo = 3; lat_hi = 3; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq_due.size() == 2) found = 1'b1;
            else step();
        end
        check_eq("two_inflight_found", found, 1);
        do_rst = 1'b1; garbage = 2;
        step();
        do_rst = 1'b0;
        repeat (10) step();

        // random traffic
        lat_lo = 1; lat_hi = 4; p_req_rdy = 70; p_id_rdy = 70; p_redir = 4;
        repeat (3000) step();

        // steady state with 1-cycle memory: one instruction per cycle
        lat_lo = 1; lat_hi = 1; p_req_rdy = 100; p_id_rdy = 100; p_redir = 0;
        repeat (15) step();
        p0 = pops;
        repeat (20) step();
        check_eq("throughput", pops - p0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V processor. Holds the program counter, issues word requests to instruction memory over a valid/ready handshake, buffers up to two returned instructions with their PCs, and presents them in order to the decode stage, whose `id_ir` feeds the immediate generator and register file. A redirect from the branch/jump resolution logic (branch, JAL, JALR) restarts fetch at a new PC and discards wrong-path instructions, including those still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `NOP_INSTR`, 32'h0000_0013: `id_ir` value at reset (ADDI x0,x0,0).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, synchronous and active-high.
- `imem_req_valid`  out  1  request to instruction memory.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word address of request (= fetch_pc, bits [1:0] always 00).
- `imem_resp_valid`  in  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  target PC; bits [1:0] are forced to 00.
- `id_valid`  out  1  buffer head is a valid instruction.
- `id_ready`  in  1  decode accepts the head this cycle.
- `id_ir`  out  32  head instruction.
- `id_pc`  out  32  PC of head instruction.
- `id_pc_plus4`  out  32  `id_pc + 4`, modulo 2^32.

## Operation
- State: `fetch_pc` (32b), `live_cnt` (0..2, in-flight requests on the correct path), `stale_cnt` (0..2, in-flight wrong-path requests), 2-entry PC queue of issued addresses, 2-entry instruction buffer {ir, pc} with `buf_cnt` (0..2).
- Invariant: `live_cnt + stale_cnt <= 2`, `live_cnt + buf_cnt <= 2`.
- Issue: `imem_req_valid = (live_cnt + stale_cnt < 2) && (live_cnt + buf_cnt < 2 || pop)`, where `pop = id_valid && id_ready`. This is not gated by `redirect_valid`.
- Acceptance (`imem_req_valid && imem_req_ready`): push `fetch_pc` to the PC queue, then `fetch_pc <= fetch_pc + 4`, wrapping at 2^32.
- Response: pop the PC queue. If `stale_cnt != 0`, discard the response and decrement `stale_cnt`. Otherwise write {data, pc} to the buffer tail and decrement `live_cnt`.
- A response that arrives when `live_cnt + stale_cnt == 0` is ignored. This covers responses that straddle a reset.
- `id_valid = (buf_cnt != 0)`. On `pop`, the buffer advances. A push and a pop in the same cycle leave `buf_cnt` unchanged.
- Redirect has priority over all of the following in its cycle:
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - The buffer is cleared.
  - All in-flight requests become stale: `stale_cnt <= live_cnt + stale_cnt + accepted − resp`, and `live_cnt <= 0`.
  - A request accepted in the redirect cycle is stale.
  - A response arriving in the redirect cycle is discarded.
  - An `id` handshake in the redirect cycle completes normally. Decode kills that instruction.
- Mode summary:
  - RUN: `stale_cnt == 0`.
  - DRAIN: `stale_cnt != 0`. New-path requests may still issue in DRAIN.
  - DRAIN → RUN when the last stale response retires.
  - A redirect while in DRAIN re-marks all in-flight requests stale, as above.

## Timing
- Reset values:
  - `fetch_pc = RESET_PC`; all counters 0; buffer empty.
  - `imem_req_valid = 0` during the reset cycle.
  - `id_valid = 0`, `id_ir = NOP_INSTR`, `id_pc = RESET_PC`, `id_pc_plus4 = RESET_PC + 4`.
- `imem_req_valid` is high the first cycle after `rst` falls, with `imem_req_addr = RESET_PC`.
- Fetch latency: request accepted at cycle t, response at t+k (k ≥ 1), `id_valid` high at t+k+1. There is no bypass from response to `id_*`.
- With a 1-cycle memory and decode always ready, throughput is 1 instruction/cycle from cycle t+2 onward.
- Redirect at cycle r: the buffer is empty and `imem_req_addr = redirect_pc` at r+1. The first new-path `id_valid` comes no earlier than r+3.
- `id_*` outputs are stable while `id_valid && !id_ready`.
- Combinational paths: `id_ready` → `imem_req_valid` only. `imem_req_ready` and `imem_resp_*` reach no output combinationally.

## Test plan
- Reset, 1-cycle memory, decode always ready, memory holds ADDI words → `id_pc` sequence 0,4,8,12 on consecutive cycles starting at cycle 3 after reset; `id_pc_plus4` = `id_pc + 4`.
- Decode stalls (`id_ready = 0`) for 5 cycles → `buf_cnt` saturates at 2, at most 2 live requests are outstanding, `id_ir`/`id_pc` hold, and no instruction is lost or duplicated after release.
- 3-cycle memory latency, 2 requests outstanding, redirect to 0x0000_0100 → both old responses are dropped, the next `id_pc` is 0x100, and no 0x8/0xC instruction ever reaches `id_*`.
- Redirect in the same cycle as a request handshake and a response; then a second redirect to 0x200 while in DRAIN → only 0x200-path instructions appear, and `stale_cnt` returns to 0.
- `redirect_pc` = 0xFFFF_FFFE → fetch at 0xFFFF_FFFC, then 0x0000_0000 (wrap), with `id_pc_plus4` = 0x0000_0000 for the first instruction.
- Assert `rst` with 2 requests in flight → outputs return to reset values the next cycle, late responses are ignored, and fetch restarts at `RESET_PC`.
